// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, NOP encoding and
// the control-transfer opcodes that IF_ID/decode also recognise.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc_in);
    return pc_in + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: control inputs, redirects, imem request/response and
// the PC/instruction pair handed to IF_ID. slave = fetch unit side.
interface pc_fetch_if #(parameter int CNT_W = 16);
  logic             start;
  logic             halt_req;
  logic             keep_instr;
  logic             branch_valid;
  logic [31:0]      branch_target;
  logic             jalr_valid;
  logic [31:0]      jalr_target;
  logic [31:0]      imem_addr;
  logic             imem_en;
  logic [31:0]      imem_rdata;
  logic [31:0]      pc;
  logic [31:0]      instr_IF;
  logic             pc_running;
  logic [CNT_W-1:0] redirect_cnt;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic             fetch_misalign;
`endif

  modport slave (
    input  start, halt_req, keep_instr,
    input  branch_valid, branch_target, jalr_valid, jalr_target,
    input  imem_rdata,
    output imem_addr, imem_en, pc, instr_IF, pc_running, redirect_cnt
`ifdef PC_FETCH_ALIGN_CHECK_EN
    , output fetch_misalign
`endif
  );

  modport master (
    output start, halt_req, keep_instr,
    output branch_valid, branch_target, jalr_valid, jalr_target,
    output imem_rdata,
    input  imem_addr, imem_en, pc, instr_IF, pc_running, redirect_cnt
`ifdef PC_FETCH_ALIGN_CHECK_EN
    , input fetch_misalign
`endif
  );

endinterface

// File: rtl/pc_fetch_next_mux.sv
// Pure next-PC priority mux: halted -> hold, jalr, branch, stall, sequential.
// Combinational; redirect flags a jalr/branch taken while running.
module pc_next_mux
  import pc_fetch_pkg::*;
(
  input  logic        run,
  input  logic [31:0] pc,
  input  logic        keep_instr,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc_next,
  output logic        redirect
);

  always_comb begin
    pc_next  = pc;
    redirect = run & (jalr_valid | branch_valid);
    if (run) begin
      if (jalr_valid)        pc_next = {jalr_target[31:1], 1'b0};
      else if (branch_valid) pc_next = branch_target;
      else if (keep_instr)   pc_next = pc;
      else                   pc_next = pc_plus4(pc);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// PC fetch unit: IDLE/RUN/HALT sequencer driving a 1-cycle synchronous imem; keep_instr
// stalls the PC, redirects override it. PC_FETCH_ALIGN_CHECK_EN traps misaligned targets.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.slave  bus
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nop_q, nop_d;
  logic [31:0]      mux_next;
  logic             redirect;
  logic             accept;
  logic             misalign;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
`endif

  pc_next_mux u_mux (
    .run           (state_q == ST_RUN),
    .pc            (pc_q),
    .keep_instr    (bus.keep_instr),
    .branch_valid  (bus.branch_valid),
    .branch_target (bus.branch_target),
    .jalr_valid    (bus.jalr_valid),
    .jalr_target   (bus.jalr_target),
    .pc_next       (mux_next),
    .redirect      (redirect)
  );

  always_comb begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
    // A misaligned target is refused outright: PC stays put and the FSM parks in HALT.
    misalign   = redirect && (mux_next[1:0] != 2'b00);
    accept     = redirect && !misalign;
    pc_d       = misalign ? pc_q : mux_next;
    misalign_d = bus.start ? 1'b0 : (misalign_q | misalign);
`else
    misalign   = 1'b0;
    accept     = redirect;
    pc_d       = redirect ? (mux_next & 32'hFFFF_FFFC) : mux_next;
`endif
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start)                 state_d = ST_RUN;
      ST_RUN:  if (misalign || bus.halt_req)  state_d = ST_HALT;
      ST_HALT: if (bus.start)                 state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
    // The word read for the first PC after entry or a redirect is squashed.
    nop_d = accept | ((state_q == ST_IDLE) & bus.start);
    cnt_d = (accept && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    run_d = (state_q == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      nop_q      <= 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      nop_q      <= nop_d;
`ifdef PC_FETCH_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign bus.imem_addr    = pc_d;
  assign bus.imem_en      = (state_q == ST_RUN);
  assign bus.pc           = pc_q;
  assign bus.instr_IF     = nop_q ? NOP_INSTR : bus.imem_rdata;
  assign bus.pc_running   = run_q;
  assign bus.redirect_cnt = cnt_q;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign bus.fetch_misalign = misalign_q;
`endif

endmodule
